muntjac_reg_file_mp: RTL and testbench
======================================

MUNTJAC_REG_FILE_MP -- requirements
Module: muntjac_reg_file_mp

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DataWidth, 64, register data width in bits.
- MetaWidth, 8, per-register metadata width in bits.
- NumRead, 2, number of read ports (1..4).
- NumWrite, 2, number of write ports (1..3).
- Bypass, 1, 1 = same-cycle write-to-read forwarding; 0 = no forwarding.
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset.
- raddr_i, in, NumRead x 5, read addresses.
- rdata_o, out, NumRead x DataWidth, read data.
- rmetadata_o, out, NumRead x MetaWidth, read metadata.
- rbusy_o, out, NumRead, pending-write flag for each read address.
- waddr_i, in, NumWrite x 5, write addresses.
- wdata_i, in, NumWrite x DataWidth, write data.
- wmetadata_i, in, NumWrite x MetaWidth, write metadata.
- we_i, in, NumWrite, write enables.
- issue_valid_i, in, 1, marks issue_addr_i as having a pending write.
- issue_addr_i, in, 5, destination register being issued.
- flush_i, in, 1, request to clear the whole file.
- ready_o, out, 1, file is initialised and accepting writes.
REQ-003 There is one clock, clk_i; rst_ni is an asynchronous, active-low reset.

Function
REQ-004 Storage: 31 entries (x1..x31), each holding DataWidth data, MetaWidth metadata and 1 pending bit; x0 has no storage.
REQ-005 Reads are combinational; raddr_i == 0 gives rdata_o = 0, rmetadata_o = 0, rbusy_o = 0.
REQ-006 While ready_o = 0, every read port returns rdata_o = 0, rmetadata_o = 0, rbusy_o = 0.
REQ-007 Writes take effect at the clk_i edge when we_i[k] = 1, ready_o = 1 and waddr_i[k] != 0; data and metadata update together.
REQ-008 Several ports writing the same address in one cycle: the highest-indexed port wins.
REQ-009 Bypass = 1: a read whose address matches an active qualifying write in the same cycle returns that port's wdata and wmetadata (highest-indexed port wins) and rbusy_o = 0; Bypass = 0: the read returns the pre-edge contents.
REQ-010 Scoreboard set: issue_valid_i = 1 with issue_addr_i != 0 and ready_o = 1 sets pending[issue_addr_i] at the edge.
REQ-011 Scoreboard clear: any qualifying write clears pending[waddr].
REQ-012 Same-cycle issue and write to the same address: pending ends at 1 (set wins).
REQ-013 rbusy_o[i] = pending[raddr_i[i]], except as overridden by REQ-009.
REQ-014 FSM state CLEAR: index counter runs 1..31, one entry per cycle; data, metadata and pending of that entry are zeroed; ready_o = 0; we_i, issue_valid_i and flush_i are ignored.
REQ-015 FSM transition CLEAR -> READY: in the cycle after index 31 is cleared; ready_o = 1 in READY.
REQ-016 FSM transition READY -> CLEAR: when flush_i = 1; the index restarts at 1; writes and issues presented in the same cycle as flush_i are discarded.
REQ-017 Latency: the file is fully cleared 31 cycles after entering CLEAR, and ready_o rises on the 32nd edge.

Reset
REQ-018 While rst_ni = 0: FSM = CLEAR, index = 1, ready_o = 0, all pending bits = 0; data and metadata need not be reset.
REQ-019 After rst_ni deasserts, the clear sequence of REQ-014 to REQ-017 runs automatically.
REQ-020 Reset asserted mid-clear or mid-operation restarts the sequence from index 1.

Verification
REQ-021 Release reset, hold we_i = 1 throughout -> ready_o = 0 for 31 edges, rises on the 32nd; all registers then read 0.
REQ-022 Write x5 = 0xDEAD on port 0 and x5 = 0xBEEF on port 1 in the same cycle -> next cycle x5 reads 0xBEEF; with Bypass = 1, a same-cycle read of x5 returns 0xBEEF.
REQ-023 Write to x0 with data 0x1234 -> raddr 0 still reads 0; no other entry changes.
REQ-024 Issue x7 -> rbusy_o = 1 for x7; write x7 -> rbusy_o = 0; issue and write x7 in the same cycle -> rbusy_o = 1 afterwards.
REQ-025 flush_i in READY with a concurrent write of x3 = 0x55 -> ready_o = 0 for 31 cycles, then x3 reads 0 and all pending bits are 0.
REQ-026 Assert rst_ni = 0 at clear index 10 -> sequence restarts; ready_o rises 32 edges after the release.

Source files
------------

// File: rtl/muntjac_reg_file_mp.sv
// Multi-ported integer register file (x1..x31) with per-entry metadata and a
// pending-write scoreboard, cleared one entry per cycle after reset or flush.
module muntjac_reg_file_mp #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MetaWidth = 8,
  parameter int unsigned NumRead   = 2,
  parameter int unsigned NumWrite  = 2,
  parameter bit          Bypass    = 1'b1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumRead-1:0][4:0]             raddr_i,
  output logic [NumRead-1:0][DataWidth-1:0]   rdata_o,
  output logic [NumRead-1:0][MetaWidth-1:0]   rmetadata_o,
  output logic [NumRead-1:0]                  rbusy_o,
  input  logic [NumWrite-1:0][4:0]            waddr_i,
  input  logic [NumWrite-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumWrite-1:0][MetaWidth-1:0]  wmetadata_i,
  input  logic [NumWrite-1:0]                 we_i,
  input  logic                                issue_valid_i,
  input  logic [4:0]                          issue_addr_i,
  input  logic                                flush_i,
  output logic                                ready_o
);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [4:0]           r_idx;
  logic [4:0]           w_idx_nxt;

  logic [DataWidth-1:0] r_data [1:31];
  logic [MetaWidth-1:0] r_meta [1:31];
  logic [31:1]          r_pending;

  logic                 w_ready;
  logic                 w_accept;
  logic [NumWrite-1:0]  w_wen;
  logic                 w_issue;

  assign w_ready  = (r_state == ST_READY);
  assign w_accept = w_ready && !flush_i;
  assign ready_o  = w_ready;
  assign w_issue  = w_accept && issue_valid_i && (issue_addr_i != 5'd0);

  always_comb begin
    w_wen = '0;
    for (int k = 0; k < NumWrite; k++) begin
      w_wen[k] = w_accept && we_i[k] && (waddr_i[k] != 5'd0);
    end
  end

  // Index 0 after wrapping from 31 marks the extra settle cycle before READY.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_CLEAR: begin
        if (r_idx == 5'd0) begin
          w_state_nxt = ST_READY;
        end else begin
          w_idx_nxt = r_idx + 5'd1;
        end
      end
      ST_READY: begin
        if (flush_i) begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = 5'd1;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_idx_nxt   = 5'd1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_CLEAR;
      r_idx   <= 5'd1;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Later ports are visited last, so the highest-indexed writer wins.
  always_ff @(posedge clk_i) begin
    for (int e = 1; e < 32; e++) begin
      if (r_state == ST_CLEAR && r_idx == 5'(e)) begin
        r_data[e] <= '0;
        r_meta[e] <= '0;
      end
      for (int k = 0; k < NumWrite; k++) begin
        if (w_wen[k] && waddr_i[k] == 5'(e)) begin
          r_data[e] <= wdata_i[k];
          r_meta[e] <= wmetadata_i[k];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending <= '0;
    end else begin
      for (int e = 1; e < 32; e++) begin
        if (r_state == ST_CLEAR && r_idx == 5'(e)) begin
          r_pending[e] <= 1'b0;
        end
        for (int k = 0; k < NumWrite; k++) begin
          if (w_wen[k] && waddr_i[k] == 5'(e)) begin
            r_pending[e] <= 1'b0;
          end
        end
        if (w_issue && issue_addr_i == 5'(e)) begin
          r_pending[e] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdata_o     = '0;
    rmetadata_o = '0;
    rbusy_o     = '0;
    if (w_ready) begin
      for (int i = 0; i < NumRead; i++) begin
        for (int e = 1; e < 32; e++) begin
          if (raddr_i[i] == 5'(e)) begin
            rdata_o[i]     = r_data[e];
            rmetadata_o[i] = r_meta[e];
            rbusy_o[i]     = r_pending[e];
          end
        end
        if (Bypass) begin
          for (int k = 0; k < NumWrite; k++) begin
            if (w_wen[k] && waddr_i[k] == raddr_i[i]) begin
              rdata_o[i]     = wdata_i[k];
              rmetadata_o[i] = wmetadata_i[k];
              rbusy_o[i]     = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_muntjac_reg_file_mp.sv
// Directed self-checking bench for muntjac_reg_file_mp with default parameters.
module tb_muntjac_reg_file_mp;

  logic             clk;
  logic             rst_n;
  logic [1:0][4:0]  raddr;
  logic [1:0][63:0] rdata;
  logic [1:0][7:0]  rmeta;
  logic [1:0]       rbusy;
  logic [1:0][4:0]  waddr;
  logic [1:0][63:0] wdata;
  logic [1:0][7:0]  wmeta;
  logic [1:0]       we;
  logic             issueValid;
  logic [4:0]       issueAddr;
  logic             flush;
  logic             ready;

  int vecCount  = 0;
  int missCount = 0;
  int edges;
  logic [63:0] orData, orMeta, orBusy;

  muntjac_reg_file_mp dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .raddr_i       (raddr),
    .rdata_o       (rdata),
    .rmetadata_o   (rmeta),
    .rbusy_o       (rbusy),
    .waddr_i       (waddr),
    .wdata_i       (wdata),
    .wmetadata_i   (wmeta),
    .we_i          (we),
    .issue_valid_i (issueValid),
    .issue_addr_i  (issueAddr),
    .flush_i       (flush),
    .ready_o       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] weV,
                               input logic [4:0] a0, input logic [63:0] d0, input logic [7:0] m0,
                               input logic [4:0] a1, input logic [63:0] d1, input logic [7:0] m1,
                               input logic iv, input logic [4:0] ia, input logic fl);
    we         = weV;
    waddr[0]   = a0;
    wdata[0]   = d0;
    wmeta[0]   = m0;
    waddr[1]   = a1;
    wdata[1]   = d1;
    wmeta[1]   = m1;
    issueValid = iv;
    issueAddr  = ia;
    flush      = fl;
  endtask

  task automatic idle();
    applyStimulus(2'b00, 5'd0, 64'd0, 8'd0, 5'd0, 64'd0, 8'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts posedges until ready is seen high; gives up after 40.
  task automatic waitReady(output int n);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (ready) begin
        idle();
        return;
      end
    end
    idle();
  endtask

  task automatic readAll(output logic [63:0] oD, output logic [63:0] oM, output logic [63:0] oB);
    oD = '0;
    oM = '0;
    oB = '0;
    for (int e = 1; e < 32; e++) begin
      raddr[0] = 5'(e);
      #0.2;
      oD = oD | rdata[0];
      oM = oM | 64'(rmeta[0]);
      oB = oB | 64'(rbusy[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    raddr = '0;
    applyStimulus(2'b11, 5'd5, 64'hAAAA, 8'h1, 5'd5, 64'hBBBB, 8'h2, 1'b1, 5'd5, 1'b0);
    raddr[0] = 5'd5;
    #2;
    checkOutput("resetReady", 64'(ready), 64'd0);
    checkOutput("resetData", rdata[0], 64'd0);
    checkOutput("resetBusy", 64'(rbusy[0]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    waitReady(edges);
    checkOutput("initReadyEdge", 64'(edges), 64'd32);
    readAll(orData, orMeta, orBusy);
    checkOutput("initDataZero", orData, 64'd0);
    checkOutput("initMetaZero", orMeta, 64'd0);
    checkOutput("initBusyZero", orBusy, 64'd0);

    // Same-address write on both ports: port 1 wins, forwarded same cycle.
    @(negedge clk);
    applyStimulus(2'b11, 5'd5, 64'hDEAD, 8'h11, 5'd5, 64'hBEEF, 8'h22, 1'b0, 5'd0, 1'b0);
    raddr[0] = 5'd5;
    raddr[1] = 5'd6;
    #1;
    checkOutput("bypassData", rdata[0], 64'hBEEF);
    checkOutput("bypassMeta", 64'(rmeta[0]), 64'h22);
    checkOutput("unrelatedRead", rdata[1], 64'd0);
    tick();
    idle();
    #1;
    checkOutput("x5Data", rdata[0], 64'hBEEF);
    checkOutput("x5Meta", 64'(rmeta[0]), 64'h22);

    // Write to x0 is dropped.
    applyStimulus(2'b01, 5'd0, 64'h1234, 8'h33, 5'd0, 64'd0, 8'd0, 1'b0, 5'd0, 1'b0);
    raddr[1] = 5'd0;
    #1;
    checkOutput("x0Bypass", rdata[1], 64'd0);
    tick();
    idle();
    #1;
    checkOutput("x0Data", rdata[1], 64'd0);
    checkOutput("x5Kept", rdata[0], 64'hBEEF);

    // Distinct addresses on the two ports, read on both read ports.
    applyStimulus(2'b11, 5'd1, 64'h1111_2222_3333_4444, 8'hA1, 5'd31, 64'hFEDC_BA98_7654_3210, 8'hB2,
                  1'b0, 5'd0, 1'b0);
    tick();
    idle();
    raddr[0] = 5'd1;
    raddr[1] = 5'd31;
    #1;
    checkOutput("x1Data", rdata[0], 64'h1111_2222_3333_4444);
    checkOutput("x31Data", rdata[1], 64'hFEDC_BA98_7654_3210);
    checkOutput("x31Meta", 64'(rmeta[1]), 64'hB2);

    // Scoreboard: issue, write-clear, then issue and write together.
    applyStimulus(2'b00, 5'd0, 64'd0, 8'd0, 5'd0, 64'd0, 8'd0, 1'b1, 5'd7, 1'b0);
    raddr[0] = 5'd8;
    raddr[1] = 5'd7;
    #1;
    checkOutput("busyBeforeIssue", 64'(rbusy[1]), 64'd0);
    tick();
    idle();
    #1;
    checkOutput("busyAfterIssue", 64'(rbusy[1]), 64'd1);
    checkOutput("neighbourNotBusy", 64'(rbusy[0]), 64'd0);
    applyStimulus(2'b10, 5'd0, 64'd0, 8'd0, 5'd7, 64'h77, 8'h07, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("busyBypassed", 64'(rbusy[1]), 64'd0);
    checkOutput("x7Bypass", rdata[1], 64'h77);
    tick();
    idle();
    #1;
    checkOutput("busyAfterWrite", 64'(rbusy[1]), 64'd0);
    applyStimulus(2'b01, 5'd7, 64'h99, 8'h09, 5'd0, 64'd0, 8'd0, 1'b1, 5'd7, 1'b0);
    tick();
    idle();
    #1;
    checkOutput("busySetWins", 64'(rbusy[1]), 64'd1);
    checkOutput("x7Data", rdata[1], 64'h99);

    // Flush with a concurrent write to x3; x3 and x9 hold state beforehand.
    applyStimulus(2'b01, 5'd3, 64'h11, 8'h01, 5'd0, 64'd0, 8'd0, 1'b1, 5'd9, 1'b0);
    tick();
    applyStimulus(2'b01, 5'd3, 64'h55, 8'h05, 5'd0, 64'd0, 8'd0, 1'b1, 5'd10, 1'b1);
    tick();
    idle();
    checkOutput("flushReadyLow", 64'(ready), 64'd0);
    waitReady(edges);
    checkOutput("flushReadyEdge", 64'(edges), 64'd32);
    raddr[1] = 5'd3;
    #1;
    checkOutput("x3AfterFlush", rdata[1], 64'd0);
    readAll(orData, orMeta, orBusy);
    checkOutput("flushDataZero", orData, 64'd0);
    checkOutput("flushBusyZero", orBusy, 64'd0);

    // Reset arriving at clear index 10 restarts the sequence.
    @(negedge clk);
    applyStimulus(2'b01, 5'd12, 64'hC0FFEE, 8'h0C, 5'd0, 64'd0, 8'd0, 1'b1, 5'd12, 1'b0);
    tick();
    applyStimulus(2'b00, 5'd0, 64'd0, 8'd0, 5'd0, 64'd0, 8'd0, 1'b0, 5'd0, 1'b1);
    tick();
    idle();
    repeat (9) tick();
    rst_n = 1'b0;
    #2;
    checkOutput("midClearReset", 64'(ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    waitReady(edges);
    checkOutput("restartReadyEdge", 64'(edges), 64'd32);
    raddr[0] = 5'd12;
    #1;
    checkOutput("x12Cleared", rdata[0], 64'd0);
    checkOutput("x12NotBusy", 64'(rbusy[0]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
